// File: rtl/i2c_seq_pkg.sv
// Shared types and defaults for the I2C transaction sequencer.
// Optional watchdog is enabled with I2C_SEQ_TIMEOUT_EN.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DONE
    } state_t;

    typedef logic [1:0] len_t;

    localparam int unsigned VALID_HOLD_DEF = 4096;
    localparam logic [23:0] TIMEOUT_DEF    = 24'd2_000_000;

    function automatic logic [7:0] lane(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Command/response handshake between a command source and the
// I2C transaction sequencer.
interface i2c_txn_sequencer_if;
    import i2c_seq_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic        cmd_rnw;
    len_t        cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;

    modport master (
        output cmd_valid, cmd_addr, cmd_rnw, cmd_len, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rnw, cmd_len, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );

endinterface

// File: rtl/i2c_seq_sync.sv
// Two-flop synchroniser with rise/fall pulses for one master status bit.
module i2c_seq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Command-level front end for i2c_master: one transaction per handshake.
// Watchdog abort is compiled in with I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned VALID_HOLD     = VALID_HOLD_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    i2c_txn_sequencer_if.slave  cmd,
    output logic                m_start,
    output logic [6:0]          m_addr,
    output logic                m_rnw,
    output logic [1:0]          m_size,
    output logic [7:0]          m_data_o,
    output logic                m_data_valid,
    input  logic                m_busy,
    input  logic                m_new_data,
    input  logic                m_data_req,
    input  logic [7:0]          m_data_i
);

    state_t      state, state_n;
    logic        busy_rise, busy_fall, busy_fell_q;
    logic        req_rise, nd_rise;
    logic        unused_req_fall, unused_nd_fall;
    logic [2:0]  idx;
    len_t        len_q;
    logic [31:0] wbuf;
    logic [31:0] hold_cnt;
    logic        accept, tmo;

    i2c_seq_sync u_busy (
        .clk(clk), .rst(rst), .d(m_busy),
        .rise(busy_rise), .fall(busy_fall)
    );
    i2c_seq_sync u_req (
        .clk(clk), .rst(rst), .d(m_data_req),
        .rise(req_rise), .fall(unused_req_fall)
    );
    i2c_seq_sync u_nd (
        .clk(clk), .rst(rst), .d(m_new_data),
        .rise(nd_rise), .fall(unused_nd_fall)
    );

    assign accept        = cmd.cmd_valid & (state == IDLE);
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.rsp_valid = (state == DONE);
    assign m_start       = (state == LAUNCH);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [23:0] tcnt;
    logic        tmo_q;

    // Offset by two so DONE lands exactly TIMEOUT_CYCLES after LAUNCH
    assign tmo = ((state == WAIT_BUSY) || (state == RUN)) &&
                 (tcnt == TIMEOUT_CYCLES - 24'd2);
    assign cmd.rsp_timeout = (state == DONE) & tmo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                tcnt  <= '0;
                tmo_q <= 1'b0;
            end else if ((state == WAIT_BUSY) || (state == RUN)) begin
                tcnt <= tcnt + 24'd1;
            end
            if (tmo) tmo_q <= 1'b1;
        end
    end
`else
    logic [23:0] unused_tmo;
    assign unused_tmo      = TIMEOUT_CYCLES;
    assign tmo             = 1'b0;
    assign cmd.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (accept) state_n = LAUNCH;
            LAUNCH:    state_n = WAIT_BUSY;
            WAIT_BUSY: if (busy_rise) state_n = RUN;
            RUN:       if (busy_fell_q) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (tmo) state_n = DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_fell_q   <= 1'b0;
            m_addr        <= '0;
            m_rnw         <= 1'b0;
            m_size        <= '0;
            m_data_o      <= '0;
            m_data_valid  <= 1'b0;
            len_q         <= '0;
            wbuf          <= '0;
            idx           <= '0;
            hold_cnt      <= '0;
            cmd.rsp_rdata <= '0;
        end else begin
            // Exit one cycle after the fall so a read byte that lands
            // together with the busy drop is still captured.
            busy_fell_q <= busy_fall & (state == RUN);
            if (accept) begin
                m_addr        <= cmd.cmd_addr;
                m_rnw         <= cmd.cmd_rnw;
                m_size        <= cmd.cmd_len;
                len_q         <= cmd.cmd_len;
                wbuf          <= cmd.cmd_wdata;
                idx           <= '0;
                cmd.rsp_rdata <= '0;
            end
            if (m_data_valid) begin
                if (hold_cnt == 32'd0) m_data_valid <= 1'b0;
                else                   hold_cnt <= hold_cnt - 32'd1;
            end
            if ((state == RUN) && !m_rnw && req_rise &&
                (idx <= {1'b0, len_q})) begin
                m_data_o     <= lane(wbuf, idx[1:0]);
                m_data_valid <= 1'b1;
                hold_cnt     <= VALID_HOLD - 32'd1;
                idx          <= idx + 3'd1;
            end
            if ((state == RUN) && m_rnw && nd_rise) begin
                cmd.rsp_rdata[{idx[1:0], 3'b000} +: 8] <= m_data_i;
                if (idx[1:0] != len_q) idx <= idx + 3'd1;
            end
            if ((busy_fall && (state == RUN)) || tmo)
                m_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench: vector table of transactions plus hand-written
// back-to-back, hold-cancel, reset and watchdog sequences.
module tb_i2c_txn_sequencer;
    import i2c_seq_pkg::*;

    localparam int VH = 8;

    typedef struct {
        logic [6:0]  addr;
        logic        rnw;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_txn_sequencer_if cif();

    logic       m_start, m_rnw, m_data_valid;
    logic [6:0] m_addr;
    logic [1:0] m_size;
    logic [7:0] m_data_o;
    logic       m_busy = 1'b0;
    logic       m_new_data = 1'b0;
    logic       m_data_req = 1'b0;
    logic [7:0] m_data_i = 8'h00;

    int total = 0;
    int bad = 0;
    vec_t vt[5];

    i2c_txn_sequencer #(
        .VALID_HOLD(VH),
        .TIMEOUT_CYCLES(24'd1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cif),
        .m_start(m_start),
        .m_addr(m_addr),
        .m_rnw(m_rnw),
        .m_size(m_size),
        .m_data_o(m_data_o),
        .m_data_valid(m_data_valid),
        .m_busy(m_busy),
        .m_new_data(m_new_data),
        .m_data_req(m_data_req),
        .m_data_i(m_data_i)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input vec_t v);
        cif.cmd_addr  = v.addr;
        cif.cmd_rnw   = v.rnw;
        cif.cmd_len   = v.len;
        cif.cmd_wdata = v.data;
        cif.cmd_valid = 1'b1;
        step(1);
        cif.cmd_valid = 1'b0;
        chk("start_hi", m_start, 1);
        chk("m_addr", m_addr, v.addr);
        chk("m_rnw", m_rnw, v.rnw);
        chk("m_size", m_size, v.len);
        chk("ready_lo", cif.cmd_ready, 0);
        step(1);
        chk("start_pulse", m_start, 0);
    endtask

    task automatic busy_up();
        m_busy = 1'b1;
        step(3);
    endtask

    task automatic wr_byte(input logic [7:0] e);
        m_data_req = 1'b1;
        step(3);
        chk("wr_data", m_data_o, e);
        chk("wr_valid", m_data_valid, 1);
        m_data_req = 1'b0;
        step(VH - 1);
        chk("hold_end", m_data_valid, 1);
        step(1);
        chk("hold_drop", m_data_valid, 0);
    endtask

    task automatic rd_byte(input logic [7:0] b);
        m_data_i   = b;
        m_new_data = 1'b1;
        step(3);
        m_new_data = 1'b0;
        step(3);
    endtask

    task automatic finish_txn(input logic [31:0] exp);
        m_busy = 1'b0;
        step(3);
        chk("rsp_early", cif.rsp_valid, 0);
        step(1);
        chk("rsp_valid", cif.rsp_valid, 1);
        chk("rsp_tmo", cif.rsp_timeout, 0);
        chk("rsp_rdata", cif.rsp_rdata, exp);
        chk("ready_done", cif.cmd_ready, 0);
        step(1);
        chk("rsp_pulse", cif.rsp_valid, 0);
        chk("ready_back", cif.cmd_ready, 1);
    endtask

    initial begin
        vec_t v;
        vt[0] = '{7'h50, 1'b0, 2'd1, 32'h0000_A55A, 32'h0};
        vt[1] = '{7'h21, 1'b1, 2'd3, 32'h4433_2211, 32'h4433_2211};
        vt[2] = '{7'h3C, 1'b1, 2'd0, 32'h0000_00C3, 32'h0000_00C3};
        vt[3] = '{7'h7F, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0};
        vt[4] = '{7'h01, 1'b1, 2'd1, 32'h0000_7E81, 32'h0000_7E81};

        cif.cmd_valid = 1'b0;
        cif.cmd_addr  = '0;
        cif.cmd_rnw   = 1'b0;
        cif.cmd_len   = '0;
        cif.cmd_wdata = '0;

        #1;
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_start", m_start, 0);
        chk("rst_rsp", cif.rsp_valid, 0);
        chk("rst_dv", m_data_valid, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_rdata", cif.rsp_rdata, 0);
        chk("rst_tmo", cif.rsp_timeout, 0);
        step(2);
        rst = 1'b1;
        step(1);

        for (int n = 0; n < 5; n++) begin
            v = vt[n];
            do_cmd(v);
            busy_up();
            for (int i = 0; i <= int'(v.len); i++) begin
                if (v.rnw) rd_byte(v.data[i*8 +: 8]);
                else       wr_byte(v.data[i*8 +: 8]);
            end
            if (!v.rnw) begin
                m_data_req = 1'b1;
                step(3);
                chk("extra_req_dv", m_data_valid, 0);
                chk("extra_req_do", m_data_o, {24'h0, v.data[int'(v.len)*8 +: 8]});
                m_data_req = 1'b0;
                step(3);
            end
            finish_txn(v.exp);
        end

        // busy fall cancels an active hold
        do_cmd('{7'h0A, 1'b0, 2'd0, 32'h0000_0077, 32'h0});
        busy_up();
        m_data_req = 1'b1;
        step(3);
        chk("cancel_dv_on", m_data_valid, 1);
        m_data_req = 1'b0;
        m_busy = 1'b0;
        step(3);
        chk("cancel_dv_off", m_data_valid, 0);
        step(1);
        chk("cancel_rsp", cif.rsp_valid, 1);
        step(1);

        // cmd_valid held through a transaction
        cif.cmd_addr  = 7'h33;
        cif.cmd_rnw   = 1'b1;
        cif.cmd_len   = 2'd0;
        cif.cmd_valid = 1'b1;
        step(1);
        chk("b2b_addr1", m_addr, 7'h33);
        cif.cmd_addr  = 7'h44;
        cif.cmd_rnw   = 1'b0;
        cif.cmd_len   = 2'd3;
        cif.cmd_wdata = 32'h0403_0201;
        step(1);
        busy_up();
        chk("b2b_run_addr", m_addr, 7'h33);
        chk("b2b_run_ready", cif.cmd_ready, 0);
        rd_byte(8'h5C);
        m_busy = 1'b0;
        step(4);
        chk("b2b_rsp", cif.rsp_valid, 1);
        chk("b2b_rdata", cif.rsp_rdata, 32'h0000_005C);
        chk("b2b_addr_hold", m_addr, 7'h33);
        step(1);
        chk("b2b_ready", cif.cmd_ready, 1);
        chk("b2b_addr_still", m_addr, 7'h33);
        step(1);
        chk("b2b_addr2", m_addr, 7'h44);
        chk("b2b_start2", m_start, 1);
        chk("b2b_rnw2", m_rnw, 0);
        cif.cmd_valid = 1'b0;
        step(1);

        // reset in the middle of byte 1 of 4
        busy_up();
        wr_byte(8'h01);
        m_data_req = 1'b1;
        step(3);
        chk("mid_data", m_data_o, 8'h02);
        chk("mid_dv", m_data_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", cif.cmd_ready, 1);
        chk("mid_rst_dv", m_data_valid, 0);
        chk("mid_rst_start", m_start, 0);
        m_data_req = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        m_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("late_fall_rsp", cif.rsp_valid, 0);
        end
        chk("late_ready", cif.cmd_ready, 1);

`ifdef I2C_SEQ_TIMEOUT_EN
        // master never raises busy: watchdog closes the transaction
        do_cmd('{7'h50, 1'b0, 2'd0, 32'h0000_0011, 32'h0});
        step(998);
        chk("tmo_early", cif.rsp_valid, 0);
        step(1);
        chk("tmo_rsp", cif.rsp_valid, 1);
        chk("tmo_flag", cif.rsp_timeout, 1);
        step(1);
        chk("tmo_ready", cif.cmd_ready, 1);
        chk("tmo_flag_clr", cif.rsp_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
